// File: rtl/spi_slave_rx.sv
// SPI receive stage: deserialises MSB-first words from ss_i/mosi_i into a small FIFO with valid/ready pop.
// Optional even-parity bit after each word is enabled by defining SPI_SLAVE_RX_PARITY_EN.
module spi_slave_rx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic                          ss_i,
    input  logic                          mosi_i,
    output logic [DATA_W-1:0]             rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    input  logic                          clr_ovr_i,
    output logic                          frame_err_o,
    output logic                          parity_err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_W);
`ifdef SPI_SLAVE_RX_PARITY_EN
    // The whole word must be held while the parity bit is sampled.
    localparam int SH_W  = DATA_W;
`else
    localparam int SH_W  = DATA_W - 1;
`endif

`ifdef SPI_SLAVE_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;

    function automatic logic parity_ok(input logic [DATA_W-1:0] w, input logic p);
        return ~(^w ^ p);
    endfunction
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SH_W-1:0]        shreg_q, shreg_d;
    logic [DATA_W-1:0]      word_in;
    logic [DATA_W-1:0]      push_word;
    logic                   push;
    logic                   frame_err_q, frame_err_d;
`ifdef SPI_SLAVE_RX_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   overrun_q, overrun_d;
    logic                   pop, full, wr_en, ovr_set;

    assign word_in = {shreg_q[DATA_W-2:0], mosi_i};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        push_word   = word_in;
        frame_err_d = 1'b0;
`ifdef SPI_SLAVE_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (!ss_i) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef SPI_SLAVE_RX_PARITY_EN
            if (cnt_q != '0 || state_q == PARITY) frame_err_d = 1'b1;
`else
            if (cnt_q != '0) frame_err_d = 1'b1;
`endif
        end else begin
            case (state_q)
`ifdef SPI_SLAVE_RX_PARITY_EN
                PARITY: begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    push_word = shreg_q;
                    if (parity_ok(shreg_q, mosi_i)) push = 1'b1;
                    else                            parity_err_d = 1'b1;
                end
`endif
                default: begin
                    // IDLE and SHIFT behave alike: counter 0 means this edge carries the MSB.
                    shreg_d = word_in[SH_W-1:0];
                    state_d = SHIFT;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d = '0;
`ifdef SPI_SLAVE_RX_PARITY_EN
                        state_d = PARITY;
`else
                        push = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        pop     = rx_valid_o && rx_ready_i;
        full    = (level_q == LVL_W'(FIFO_DEPTH));
        // A pop on the same edge frees the slot the write needs.
        wr_en   = push && (!full || pop);
        ovr_set = push && full && !pop;

        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = push_word;

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        overrun_d = overrun_q;
        if (ovr_set)        overrun_d = 1'b1;
        else if (clr_ovr_i) overrun_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
`ifdef SPI_SLAVE_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_SLAVE_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
        end
    end

    // Shift register content is qualified by the counter, so it needs no reset.
    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
    end

    assign rx_data_o   = mem_q[rd_ptr_q];
    assign rx_valid_o  = (level_q != '0);
    assign level_o     = level_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
`ifdef SPI_SLAVE_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
    assign busy_o       = ((state_q != IDLE) && (cnt_q != '0)) || (state_q == PARITY);
`else
    assign parity_err_o = 1'b0;
    assign busy_o       = (state_q != IDLE) && (cnt_q != '0);
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios followed by random serial traffic,
// compared against a bit-queue/word-queue reference model.
module tb_spi_slave_rx;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef SPI_SLAVE_RX_PARITY_EN
    localparam int WLEN = DATA_W + 1;
`else
    localparam int WLEN = DATA_W;
`endif

    logic              clk_i = 1'b0;
    logic              arstn_i = 1'b0;
    logic              ss_i = 1'b0;
    logic              mosi_i = 1'b0;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              rx_ready_i = 1'b0;
    logic [2:0]        level_o;
    logic              busy_o;
    logic              overrun_o;
    logic              clr_ovr_i = 1'b0;
    logic              frame_err_o;
    logic              parity_err_o;

    spi_slave_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .ss_i         (ss_i),
        .mosi_i       (mosi_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .level_o      (level_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .clr_ovr_i    (clr_ovr_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: received words, bits of the word in flight, sticky/pulse flags.
    logic [DATA_W-1:0] mq [$];
    int  nb   = 0;
    int  bits = 0;
    bit  m_ovr  = 1'b0;
    bit  m_ferr = 1'b0;
    bit  m_perr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid",     32'(rx_valid_o),   32'(mq.size() > 0));
        chk("level",     32'(level_o),      32'(mq.size()));
        chk("busy",      32'(busy_o),       32'(nb != 0));
        chk("overrun",   32'(overrun_o),    32'(m_ovr));
        chk("frame_err", 32'(frame_err_o),  32'(m_ferr));
        chk("par_err",   32'(parity_err_o), 32'(m_perr));
        if (mq.size() > 0) chk("data", 32'(rx_data_o), 32'(mq[0]));
    endtask

    task automatic model_edge(input bit ss, input bit mosi, input bit ready, input bit clr);
        bit pop, push;
        int sz;
        logic [DATA_W-1:0] w;
        sz     = mq.size();
        pop    = (sz > 0) && ready;
        push   = 1'b0;
        w      = '0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        if (ss) begin
            bits = (bits << 1) | int'(mosi);
            nb++;
            if (nb == WLEN) begin
`ifdef SPI_SLAVE_RX_PARITY_EN
                if (^bits) m_perr = 1'b1;
                else begin
                    push = 1'b1;
                    w    = DATA_W'(bits >> 1);
                end
`else
                push = 1'b1;
                w    = DATA_W'(bits);
`endif
                nb   = 0;
                bits = 0;
            end
        end else begin
            if (nb != 0) m_ferr = 1'b1;
            nb   = 0;
            bits = 0;
        end
        if (clr) m_ovr = 1'b0;
        if (push && sz == DEPTH && !pop) m_ovr = 1'b1;
        if (pop) void'(mq.pop_front());
        if (push && (sz < DEPTH || pop)) mq.push_back(w);
    endtask

    task automatic step(input bit ss, input bit mosi, input bit ready, input bit clr);
        @(negedge clk_i);
        ss_i       = ss;
        mosi_i     = mosi;
        rx_ready_i = ready;
        clr_ovr_i  = clr;
        @(posedge clk_i);
        model_edge(ss, mosi, ready, clr);
        #1;
        check_model();
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit ready, input bit ready_last);
        for (int i = DATA_W - 1; i >= 0; i--) begin
`ifdef SPI_SLAVE_RX_PARITY_EN
            step(1'b1, w[i], ready, 1'b0);
`else
            step(1'b1, w[i], (i == 0) ? ready_last : ready, 1'b0);
`endif
        end
`ifdef SPI_SLAVE_RX_PARITY_EN
        step(1'b1, ^w, ready_last, 1'b0);
`endif
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_data",  32'(rx_data_o),    32'h0);
        chk("rst_valid", 32'(rx_valid_o),   32'h0);
        chk("rst_level", 32'(level_o),      32'h0);
        chk("rst_busy",  32'(busy_o),       32'h0);
        chk("rst_ovr",   32'(overrun_o),    32'h0);
        chk("rst_ferr",  32'(frame_err_o),  32'h0);
        chk("rst_perr",  32'(parity_err_o), 32'h0);
        @(negedge clk_i);
        arstn_i = 1'b1;

        // Single word, consumer ready
        send_word(8'hA5, 1'b1, 1'b1);
        chk("a5_data",  32'(rx_data_o), 32'hA5);
        chk("a5_level", 32'(level_o),   32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_popped", 32'(level_o), 32'h0);

        // Back-to-back words into a stalled consumer, fifth overruns
        for (int k = 1; k <= 5; k++) send_word(DATA_W'(k), 1'b0, 1'b0);
        chk("ovr_level", 32'(level_o),   32'h4);
        chk("ovr_flag",  32'(overrun_o), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", 32'(rx_data_o), 32'(k));
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(overrun_o), 32'h0);

        // Truncated frame then a good one
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ferr_pulse", 32'(frame_err_o), 32'h1);
        chk("ferr_nowr",  32'(level_o),     32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ferr_gone",  32'(frame_err_o), 32'h0);
        send_word(8'h3C, 1'b0, 1'b0);
        chk("after_ferr", 32'(rx_data_o), 32'h3C);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Full FIFO with a pop on the last edge of the fifth word
        for (int k = 0; k < 4; k++) send_word(DATA_W'(8'h10 + k), 1'b0, 1'b0);
        send_word(8'h14, 1'b0, 1'b1);
        chk("popfull_level", 32'(level_o),   32'h4);
        chk("popfull_ovr",   32'(overrun_o), 32'h0);
        chk("popfull_head",  32'(rx_data_o), 32'h11);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-word with two words buffered
        send_word(8'h5A, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        arstn_i = 1'b0;
        #1;
        chk("arst_data",  32'(rx_data_o),  32'h0);
        chk("arst_valid", 32'(rx_valid_o), 32'h0);
        chk("arst_level", 32'(level_o),    32'h0);
        chk("arst_busy",  32'(busy_o),     32'h0);
        mq.delete();
        nb = 0;
        bits = 0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        @(negedge clk_i);
        ss_i = 1'b0;
        arstn_i = 1'b1;

`ifdef SPI_SLAVE_RX_PARITY_EN
        // Parity good then parity bad
        send_word(8'hA5, 1'b0, 1'b0);
        chk("par_ok_level", 32'(level_o), 32'h1);
        for (int i = DATA_W - 1; i >= 0; i--) step(1'b1, 1'(8'hA5 >> i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_bad_pulse", 32'(parity_err_o), 32'h1);
        chk("par_bad_level", 32'(level_o),      32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 16) != 0, 1'($urandom), ($urandom % 3) == 0, ($urandom % 25) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Serial-to-parallel receive stage sitting directly downstream of the SPI master: it consumes the master's `ss`/`MOSI` stream, deserialises bytes MSB-first, and buffers them in a small FIFO. Bytes are presented to the consuming logic over a valid/ready handshake. Overrun and truncated-frame conditions are flagged rather than silently absorbed.

## Interface
- `DATA_W`, 8, bits per received word.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥2.
- `clk_i`  in  1  system clock; single clock domain, also the bit clock.
- `arstn_i`  in  1  reset; asynchronous, active-low.
- `ss_i`  in  1  slave select, active-high (driven by master `ss_o`).
- `mosi_i`  in  1  serial data, MSB first.
- `rx_data_o`  out  DATA_W  FIFO head word.
- `rx_valid_o`  out  1  FIFO non-empty.
- `rx_ready_i`  in  1  consumer accepts head word when high with `rx_valid_o`.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `busy_o`  out  1  high while a word is partially received.
- `overrun_o`  out  1  sticky; a completed word was dropped because the FIFO was full.
- `clr_ovr_i`  in  1  synchronous clear of `overrun_o`.
- `frame_err_o`  out  1  one-cycle pulse; `ss_i` dropped mid-word.
- `parity_err_o`  out  1  one-cycle pulse; parity mismatch (see Configuration).

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE: bit counter = 0. The first rising edge of `clk_i` with `ss_i`=1 samples `mosi_i` as bit DATA_W-1 and moves to SHIFT.
- SHIFT: each edge with `ss_i`=1 shifts in one bit.
  - On the edge sampling bit 0, the word is complete. It is written to the FIFO, or goes to PARITY when the macro is defined.
  - The counter then returns to 0 and the FSM stays in SHIFT. The next edge with `ss_i`=1 starts the next word, so back-to-back words need no gap.
- `ss_i`=0 at an edge:
  - Counter = 0: clean return to IDLE, no flag.
  - Counter ≠ 0: partial word discarded, `frame_err_o` pulses, return to IDLE.
- FIFO write when full:
  - With a pop (`rx_valid_o`&&`rx_ready_i`) on the same edge, the write is accepted and no overrun occurs.
  - Without a pop, the word is dropped and `overrun_o` sets.
- `overrun_o` holds until an edge with `clr_ovr_i`=1. If a clear and a new overrun coincide, the set wins.
- Pop: head advances on an edge where `rx_valid_o`&&`rx_ready_i`. A pop on an empty FIFO is impossible by definition of `rx_valid_o`.
- Pointers wrap modulo FIFO_DEPTH. `level_o` = writes − pops, range 0..FIFO_DEPTH.
- `busy_o` = (state≠IDLE) && counter≠0, plus PARITY state.

## Timing
- Reset values: `rx_data_o`=0, `rx_valid_o`=0, `level_o`=0, `busy_o`=0, `overrun_o`=0, `frame_err_o`=0, `parity_err_o`=0. State = IDLE, FIFO empty.
- Assertion of `arstn_i` mid-word or mid-FIFO clears everything immediately. The partial word and all buffered words are lost.
- Latency, FIFO empty beforehand: `rx_valid_o`=1 and `rx_data_o` valid in the cycle after the edge that sampled the last bit (bit 0, or the parity bit with the macro).
- `rx_data_o` is driven from FIFO storage and changes only after a pop or after a write into an empty FIFO.
- `frame_err_o` and `parity_err_o` are high for exactly the one cycle following the offending edge.
- Throughput: one word per DATA_W cycles (DATA_W+1 with the macro) sustained, provided the consumer holds `rx_ready_i`=1.

## Configuration
- Macro: `SPI_SLAVE_RX_PARITY_EN`.
- Defined:
  - After bit 0, one more `ss_i`=1 edge samples an even-parity bit (PARITY state).
  - XOR of the data bits and the parity bit must be 0. On a match the word is written to the FIFO; on a mismatch the word is dropped, `parity_err_o` pulses, and there is no overrun evaluation.
  - `ss_i`=0 at the PARITY edge counts as a mid-word drop and pulses `frame_err_o`.
- Undefined: no PARITY state, and `parity_err_o` is tied to 0.

## Test plan
- Reset then `ss_i`=1 and serial 0xA5 MSB-first over 8 edges, with `rx_ready_i`=1 → `rx_valid_o`=1 with `rx_data_o`=0xA5 in the cycle after the 8th edge, `level_o`=1, then 0 after the pop.
- Continuous `ss_i`=1 for 0x01,0x02,0x03,0x04,0x05 with `rx_ready_i`=0 (DEPTH 4) → `level_o`=4 and `overrun_o`=1 after the 5th word. Draining yields 0x01..0x04. `clr_ovr_i` then clears the flag.
- `ss_i` dropped after 3 bits → `frame_err_o` one-cycle pulse, no FIFO write. A following full 0x3C frame is received correctly.
- FIFO full with a pop on the same edge as the 5th word's last bit → no overrun, `level_o` stays 4, and the 5th word is stored.
- `arstn_i` asserted mid-word with 2 words buffered → all outputs 0 immediately, `level_o`=0.
- Macro defined: 0xA5 with parity 0 → accepted. 0xA5 with parity 1 → `parity_err_o` pulse, `level_o` unchanged.
